jk_count_drv: RTL
=================

Name: jk_count_drv

Overview:
- Upstream driver for a bank of WIDTH plain JK flip-flops. The flip-flops have no reset.
- Computes per-bit j/k excitation each cycle so the bank steps through a mod-MODULUS up/down count with load and one-shot stop.
- Keeps a registered shadow copy of the bank state and flags the wrap/terminal events.
- The bank is clocked by the same clk, so bank Q equals the shadow count after every edge.

Parameters:
- WIDTH, 4: bits in the driven JK bank.
- MODULUS, 10: count range 0..MODULUS-1. Requires 2 <= MODULUS <= 2**WIDTH.

Ports:
- clk  in  1  rising-edge clock, shared with the JK bank
- rst  in  1  synchronous active-high reset
- en  in  1  advance count this cycle
- up  in  1  1 = increment, 0 = decrement
- oneshot  in  1  1 = stop at terminal instead of wrapping
- load  in  1  load load_val this cycle
- load_val  in  WIDTH  value to load
- q_fb  in  WIDTH  Q outputs of the JK bank (used only with JK_FB_CHECK_EN)
- j  out  WIDTH  J inputs to the bank (combinational)
- k  out  WIDTH  K inputs to the bank (combinational)
- count  out  WIDTH  registered shadow of bank state
- wrap  out  1  registered one-cycle pulse: count wrapped
- done  out  1  registered level: one-shot terminal reached
- fb_err  out  1  sticky feedback mismatch flag

Behaviour:
- JK encoding is fixed: 00 hold, 01 reset, 10 set, 11 toggle.
- Excitation: per bit, cur=count[i], nxt=next[i].
  - 0->1 gives j=1,k=0.
  - 1->0 gives j=0,k=1.
  - Unchanged gives j=0,k=0.
  - Code 11 is never emitted.
- While rst=1:
  - j=0 and k=all-ones, so the bank clears at each edge.
  - At the edge: count=0, wrap=0, done=0, fb_err=0, state=INIT.
- FSM states: INIT, RUN, DONE.
  - INIT: one cycle. Drives clear again (next=0), then moves to RUN. Inputs are ignored.
  - RUN: computes next by priority, highest first:
    - load: next = load_val if load_val < MODULUS, else MODULUS-1.
    - en & up: next = count+1, or 0 if count = MODULUS-1 (wrap).
    - en & !up: next = count-1, or MODULUS-1 if count = 0 (wrap).
    - otherwise: next = count (hold).
  - Wrap with oneshot=1: next = count (hold at terminal). State goes to DONE, done=1, wrap=0.
  - Wrap with oneshot=0: wrap=1 during the cycle the wrapped count is visible.
  - DONE: holds count and ignores en. Only load exits: load applies and moves to RUN with done=0.
- load together with en: load wins; no wrap and no done.
- Latency:
  - j/k are combinational in the same cycle as the command.
  - Bank and count update at the next edge.
  - wrap and done are valid in the same cycle as the new count.
- Arithmetic: WIDTH-bit unsigned, with no overflow beyond MODULUS-1.
- rst mid-count: takes effect at the next edge. The in-flight command is discarded.

Optional Feature:
- Macro: JK_FB_CHECK_EN.
- When defined, in RUN/DONE, if q_fb != count:
  - fb_err is set and stays set (sticky until rst).
  - That cycle's next is forced to count, with absolute write j=count, k=~count. This resyncs the bank.
  - The command in that cycle is dropped.
- When not defined:
  - q_fb is unused.
  - fb_err is constant 0.

Decomposition:
- Package jk_pkg holds:
  - encoding constants JK_HOLD, JK_RST, JK_SET, JK_TGL
  - state enum st_e {ST_INIT, ST_RUN, ST_DONE}
- Sub-module jk_excite: combinational per-vector cur/nxt to j/k mapping. Reused by any future JK-bank driver.

Test Plan:
- rst high for 2 cycles, then low. Expect j=0, k=4'hF during rst; count=0 after. Cycle 1 is INIT; RUN from cycle 2.
- en=1, up=1, oneshot=0 for 12 cycles. Expect count 1..9, 0, 1, 2. wrap=1 only in the cycle count returns to 0. At count 3 to 4: j=4'b0100, k=4'b0011.
- load=1, load_val=13. Expect count=9. Then en=1, up=0, oneshot=1 from count=1. Expect 0 next; on the following cycle done=1, count holds 0, wrap=0.
- In DONE, load=1, load_val=5 with en=1. Expect count=5, done=0, state RUN. Next cycle en=1, up=1 gives 6.
- load=1 and en=1 with count=9, up=1. Expect count=load_val (e.g. 2) and no wrap pulse.
- JK_FB_CHECK_EN defined, bench forces q_fb=4'h3 while count=4'h7. Expect fb_err=1 (sticky), j=4'h7, k=4'h8 that cycle. The en step is dropped and count stays 7.

Source files
------------

// File: rtl/jk_pkg.sv
// jk_pkg: shared JK encoding constants, driver FSM states and a per-bit
// excitation helper used by any JK-bank driver.
package jk_pkg;

    // {j,k} codes as seen by a plain JK flip-flop
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_DONE
    } st_e;

    // Minimal excitation for one bit; toggle is never produced so the
    // bank never depends on its own current value to reach nxt.
    function automatic logic [1:0] jk_code(input logic cur, input logic nxt);
        if (cur == nxt) return JK_HOLD;
        else if (nxt)   return JK_SET;
        else            return JK_RST;
    endfunction

endpackage

// File: rtl/jk_excite.sv
// jk_excite: combinational cur/nxt -> j/k mapping for a W-bit JK bank.
module jk_excite
    import jk_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] cur_i,
    input  logic [W-1:0] nxt_i,
    output logic [W-1:0] j_o,
    output logic [W-1:0] k_o
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        logic [1:0] code;
        // Per-bit code split onto the j and k lines
        assign code   = jk_code(cur_i[i], nxt_i[i]);
        assign j_o[i] = code[1];
        assign k_o[i] = code[0];
    end

endmodule

// File: rtl/jk_count_drv.sv
// jk_count_drv: drives a reset-less JK flip-flop bank through a mod-MODULUS
// up/down count with load and one-shot stop, keeping a registered shadow.
// Optional macro JK_FB_CHECK_EN: compare bank Q (q_fb) to the shadow and
// resync the bank on mismatch, raising a sticky fb_err.
// MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH.
module jk_count_drv
    import jk_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             oneshot,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             done,
    output logic             fb_err
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

    st_e              state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q,  wrap_d;
    logic             done_q;
    logic             clr;      // absolute clear of the bank
    logic             resync;   // absolute write of count_q into the bank
    logic             fb_bad;
    logic [WIDTH-1:0] ex_j, ex_k;
    logic [WIDTH-1:0] load_clamp, step_val, wrap_val;
    logic             at_term;

    // Out-of-range loads saturate to the top of the range
    assign load_clamp = (load_val > MAX_V) ? MAX_V : load_val;
    assign at_term    = up ? (count_q == MAX_V) : (count_q == '0);
    assign step_val   = up ? (count_q + ONE_V) : (count_q - ONE_V);
    assign wrap_val   = up ? '0 : MAX_V;

`ifdef JK_FB_CHECK_EN
    logic fb_err_q;

    assign fb_bad = (q_fb != count_q);

    // Sticky mismatch flag, cleared only by rst
    always_ff @(posedge clk) begin
        if (rst)         fb_err_q <= 1'b0;
        else if (resync) fb_err_q <= 1'b1;
    end

    assign fb_err = fb_err_q;
`else
    logic unused_q_fb;

    assign unused_q_fb = ^q_fb;
    assign fb_bad      = 1'b0;
    assign fb_err      = 1'b0;
`endif

    // Next-state / next-count selection by command priority
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        wrap_d  = 1'b0;
        clr     = 1'b0;
        resync  = 1'b0;
        case (state_q)
            ST_INIT: begin
                // Bank has no reset: clear it once more after rst drops
                clr     = 1'b1;
                count_d = '0;
                state_d = ST_RUN;
            end
            ST_RUN, ST_DONE: begin
                if (fb_bad) begin
                    resync = 1'b1;
                end else if (load) begin
                    count_d = load_clamp;
                    state_d = ST_RUN;
                end else if (en && state_q == ST_RUN) begin
                    if (at_term) begin
                        if (oneshot) begin
                            state_d = ST_DONE;
                        end else begin
                            count_d = wrap_val;
                            wrap_d  = 1'b1;
                        end
                    end else begin
                        count_d = step_val;
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase
        if (rst) clr = 1'b1;
    end

    jk_excite #(.W(WIDTH)) u_excite (
        .cur_i (count_q),
        .nxt_i (count_d),
        .j_o   (ex_j),
        .k_o   (ex_k)
    );

    // Bank drive: absolute clear, absolute resync, or minimal excitation
    always_comb begin
        if (clr) begin
            j = '0;
            k = '1;
        end else if (resync) begin
            j = count_q;
            k = ~count_q;
        end else begin
            j = ex_j;
            k = ex_k;
        end
    end

    // Shadow count, state and event flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            count_q <= '0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
            done_q  <= (state_d == ST_DONE);
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;
    assign done  = done_q;

endmodule
